// File: rtl/cp0_ctrl_if.sv
// CP0 access bus: register read/write port, interrupt lines, pipeline event inputs and exception redirect.
// master = pipeline side driving requests, slave = the CP0 block.
interface cp0_ctrl_if #(
   parameter int NUM_HW_INT = 6
);
   logic                  we;
   logic [4:0]            waddr;
   logic [31:0]           wdata;
   logic [4:0]            raddr;
   logic [31:0]           rdata;
   logic [NUM_HW_INT-1:0] hw_int;
   logic                  pc_valid;
   logic [31:0]           pc;
   logic                  in_delay_slot;
   logic [4:0]            exc_req;
   logic                  exc_flush;
   logic [31:0]           exc_target;
   logic                  int_pending;
   logic                  timer_int;
   logic [31:0]           status;
   logic [31:0]           cause;
   logic [31:0]           epc;

   modport master (
      output we, waddr, wdata, raddr, hw_int, pc_valid, pc, in_delay_slot, exc_req,
      input  rdata, exc_flush, exc_target, int_pending, timer_int, status, cause, epc
   );

   modport slave (
      input  we, waddr, wdata, raddr, hw_int, pc_valid, pc, in_delay_slot, exc_req,
      output rdata, exc_flush, exc_target, int_pending, timer_int, status, cause, epc
   );
endinterface

// File: rtl/cp0_ctrl.sv
// MIPS-style CP0: Count/Compare timer, Status/Cause/EPC, exception/eret sequencing; state updates next edge.
// rdata/exc_flush/exc_target are combinational from pre-edge state; no backpressure, one event per cycle.
module cp0_ctrl #(
   parameter int          NUM_HW_INT   = 6,
   parameter int          TIMER_IP     = 7,
   parameter int          COUNT_DIV    = 1,
   parameter logic [31:0] RESET_STATUS = 32'h1000_0000,
   parameter logic [31:0] EXC_VECTOR   = 32'hBFC0_0380,
   parameter logic [31:0] PRID         = 32'h0001_0001
) (
   input  logic       clk,
   input  logic       rst,
   cp0_ctrl_if.slave  cp0_io
);

   typedef enum logic [2:0] {
      EV_NONE, EV_INT, EV_RI, EV_OV, EV_SYS, EV_BRK, EV_ERET
   } ev_e;

   logic [31:0]           count_q, count_d;
   logic [31:0]           compare_q, compare_d;
   logic [31:0]           status_q, status_d;
   logic [31:0]           epc_q, epc_d;
   logic                  bd_q, bd_d;
   logic                  ti_q, ti_d;
   logic [1:0]            ip_sw_q, ip_sw_d;
   logic [4:0]            exc_code_q, exc_code_d;
   logic                  phase_q, phase_d;
   logic [NUM_HW_INT-1:0] hw_q;

   logic [5:0]  hw_ext;
   logic [7:0]  ip;
   logic [31:0] cause_live;
   logic        int_raw;
   ev_e         ev;
   logic [4:0]  ev_code;
   logic [31:0] epc_entry;
   logic        tick;
   logic [31:0] rd_mux;

   // IP is rebuilt every cycle so reads and the interrupt check see the live value
   always_comb begin
      hw_ext = '0;
      hw_ext[NUM_HW_INT-1:0] = hw_q;
      ip = {hw_ext, ip_sw_q};
      ip[TIMER_IP] = ip[TIMER_IP] | ti_q;
   end

   assign cause_live = {bd_q, ti_q, 14'd0, ip, 1'b0, exc_code_q, 2'b00};
   assign int_raw    = status_q[0] & ~status_q[1] & (|(ip & status_q[15:8]));

   always_comb begin
      ev = EV_NONE;
      if (!rst && cp0_io.pc_valid) begin
         if (int_raw)                ev = EV_INT;
         else if (cp0_io.exc_req[2]) ev = EV_RI;
         else if (cp0_io.exc_req[3]) ev = EV_OV;
         else if (cp0_io.exc_req[0]) ev = EV_SYS;
         else if (cp0_io.exc_req[1]) ev = EV_BRK;
         else if (cp0_io.exc_req[4]) ev = EV_ERET;
      end
   end

   always_comb begin
      ev_code = 5'd0;
      case (ev)
         EV_RI:   ev_code = 5'd10;
         EV_OV:   ev_code = 5'd12;
         EV_SYS:  ev_code = 5'd8;
         EV_BRK:  ev_code = 5'd9;
         default: ev_code = 5'd0;
      endcase
   end

   // syscall/break resume after the trapping instruction; a delay-slot event restarts at the branch
   always_comb begin
      if (cp0_io.in_delay_slot)               epc_entry = cp0_io.pc - 32'd4;
      else if (ev == EV_SYS || ev == EV_BRK)  epc_entry = cp0_io.pc + 32'd4;
      else                                    epc_entry = cp0_io.pc;
   end

   always_comb begin
      count_d    = count_q;
      compare_d  = compare_q;
      status_d   = status_q;
      epc_d      = epc_q;
      bd_d       = bd_q;
      ti_d       = ti_q;
      ip_sw_d    = ip_sw_q;
      exc_code_d = exc_code_q;
      phase_d    = ~phase_q;
      tick       = (COUNT_DIV == 2) ? phase_q : 1'b1;

      if (tick) count_d = count_q + 32'd1;
      if (cp0_io.we) begin
         case (cp0_io.waddr)
            5'd9: begin
               count_d = cp0_io.wdata;
               phase_d = 1'b0;
            end
            5'd11:   compare_d = cp0_io.wdata;
            5'd12:   status_d  = cp0_io.wdata;
            5'd13:   ip_sw_d   = cp0_io.wdata[9:8];
            5'd14:   epc_d     = cp0_io.wdata;
            default: ;
         endcase
      end

      // a Compare write acknowledges the timer even if the match lands on the same edge
      if (cp0_io.we && cp0_io.waddr == 5'd11) ti_d = 1'b0;
      else if (compare_q != 32'd0 && count_d == compare_q) ti_d = 1'b1;

      if (ev == EV_ERET) begin
         status_d[1] = 1'b0;
      end else if (ev != EV_NONE) begin
         status_d[1] = 1'b1;
         exc_code_d  = ev_code;
         if (!status_q[1]) begin
            epc_d = epc_entry;
            bd_d  = cp0_io.in_delay_slot;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q    <= '0;
         compare_q  <= '0;
         status_q   <= RESET_STATUS;
         epc_q      <= '0;
         bd_q       <= 1'b0;
         ti_q       <= 1'b0;
         ip_sw_q    <= '0;
         exc_code_q <= '0;
         phase_q    <= 1'b0;
         hw_q       <= '0;
      end else begin
         count_q    <= count_d;
         compare_q  <= compare_d;
         status_q   <= status_d;
         epc_q      <= epc_d;
         bd_q       <= bd_d;
         ti_q       <= ti_d;
         ip_sw_q    <= ip_sw_d;
         exc_code_q <= exc_code_d;
         phase_q    <= phase_d;
         hw_q       <= cp0_io.hw_int;
      end
   end

   always_comb begin
      rd_mux = '0;
      case (cp0_io.raddr)
         5'd9:    rd_mux = count_q;
         5'd11:   rd_mux = compare_q;
         5'd12:   rd_mux = status_q;
         5'd13:   rd_mux = cause_live;
         5'd14:   rd_mux = epc_q;
         5'd15:   rd_mux = PRID;
         default: rd_mux = '0;
      endcase
   end

   assign cp0_io.rdata       = rst ? 32'd0 : rd_mux;
   assign cp0_io.exc_flush   = (ev != EV_NONE);
   assign cp0_io.exc_target  = (ev == EV_ERET) ? epc_q : EXC_VECTOR;
   assign cp0_io.int_pending = ~rst & int_raw;
   assign cp0_io.timer_int   = ti_q;
   assign cp0_io.status      = status_q;
   assign cp0_io.cause       = cause_live;
   assign cp0_io.epc         = epc_q;

endmodule

// File: tb/tb_cp0_ctrl.sv
// Bench for cp0_ctrl: directed scenarios then random traffic, all checked against a reference model.
module tb_cp0_ctrl;
   localparam logic [31:0] RESET_STATUS = 32'h1000_0000;
   localparam logic [31:0] EXC_VECTOR   = 32'hBFC0_0380;
   localparam logic [31:0] PRID         = 32'h0001_0001;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   cp0_ctrl_if #(.NUM_HW_INT(6)) bus1 ();
   cp0_ctrl_if #(.NUM_HW_INT(6)) bus2 ();

   cp0_ctrl #(.NUM_HW_INT(6), .TIMER_IP(7), .COUNT_DIV(1), .RESET_STATUS(RESET_STATUS),
              .EXC_VECTOR(EXC_VECTOR), .PRID(PRID)) dut1 (.clk(clk), .rst(rst), .cp0_io(bus1));
   cp0_ctrl #(.NUM_HW_INT(6), .TIMER_IP(7), .COUNT_DIV(2), .RESET_STATUS(RESET_STATUS),
              .EXC_VECTOR(EXC_VECTOR), .PRID(PRID)) dut2 (.clk(clk), .rst(rst), .cp0_io(bus2));

   int checks   = 0;
   int failures = 0;

   // architectural view of the default instance
   logic [31:0] m_count, m_compare, m_status, m_epc;
   logic        m_bd, m_ti;
   logic [4:0]  m_code;
   logic [1:0]  m_ipsw;
   logic [5:0]  m_hw;

   bit          d2_on = 1'b0;
   logic [31:0] d2_base;
   int          d2_k;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic int prio_bit(input int k);
      case (k)
         0: return 2;
         1: return 3;
         2: return 0;
         default: return 1;
      endcase
   endfunction

   function automatic logic [4:0] prio_code(input int k);
      case (k)
         0: return 5'd10;
         1: return 5'd12;
         2: return 5'd8;
         default: return 5'd9;
      endcase
   endfunction

   task automatic model_reset();
      m_count = '0; m_compare = '0; m_status = RESET_STATUS; m_epc = '0;
      m_bd = 1'b0; m_ti = 1'b0; m_code = '0; m_ipsw = '0; m_hw = '0;
   endtask

   // check outputs mid-cycle, then advance the model and the clock together
   task automatic cycle();
      logic [7:0]  ip;
      bit          pend;
      int          kind;
      logic [4:0]  code;
      logic [31:0] e_rd, e_cause, new_cnt;
      bit          old_exl;
      @(negedge clk);
      ip = {m_hw, m_ipsw};
      if (m_ti) ip[7] = 1'b1;
      pend = m_status[0] && !m_status[1] && ((ip & m_status[15:8]) != 8'd0);
      e_cause = {m_bd, m_ti, 14'd0, ip, 1'b0, m_code, 2'b00};
      kind = 0;
      code = m_code;
      if (!rst && bus1.pc_valid) begin
         if (pend) begin
            kind = 1;
            code = 5'd0;
         end else begin
            for (int k = 0; k < 4; k++)
               if (kind == 0 && bus1.exc_req[prio_bit(k)]) begin
                  kind = 1;
                  code = prio_code(k);
               end
            if (kind == 0 && bus1.exc_req[4]) kind = 2;
         end
      end
      case (bus1.raddr)
         5'd9:    e_rd = m_count;
         5'd11:   e_rd = m_compare;
         5'd12:   e_rd = m_status;
         5'd13:   e_rd = e_cause;
         5'd14:   e_rd = m_epc;
         5'd15:   e_rd = PRID;
         default: e_rd = 32'd0;
      endcase
      if (rst) e_rd = 32'd0;

      chk("exc_flush", {31'd0, bus1.exc_flush}, {31'd0, kind != 0});
      if (kind != 0) chk("exc_target", bus1.exc_target, (kind == 2) ? m_epc : EXC_VECTOR);
      chk("int_pending", {31'd0, bus1.int_pending}, {31'd0, !rst && pend});
      chk("rdata", bus1.rdata, e_rd);
      chk("status", bus1.status, m_status);
      chk("cause", bus1.cause, e_cause);
      chk("epc", bus1.epc, m_epc);
      chk("timer_int", {31'd0, bus1.timer_int}, {31'd0, m_ti});
      if (d2_on) chk("div2_count", bus2.rdata, d2_base + 32'(d2_k / 2));

      if (rst) begin
         model_reset();
      end else begin
         old_exl = m_status[1];
         new_cnt = (bus1.we && bus1.waddr == 5'd9) ? bus1.wdata : m_count + 32'd1;
         if (bus1.we && bus1.waddr == 5'd11) begin
            m_ti = 1'b0;
            m_compare = bus1.wdata;
         end else if (m_compare != 32'd0 && new_cnt == m_compare) begin
            m_ti = 1'b1;
         end
         m_count = new_cnt;
         if (bus1.we && bus1.waddr == 5'd12) m_status = bus1.wdata;
         if (bus1.we && bus1.waddr == 5'd13) m_ipsw = bus1.wdata[9:8];
         if (bus1.we && bus1.waddr == 5'd14) m_epc = bus1.wdata;
         if (kind == 2) begin
            m_status[1] = 1'b0;
         end else if (kind == 1) begin
            m_status[1] = 1'b1;
            m_code = code;
            if (!old_exl) begin
               m_bd = bus1.in_delay_slot;
               if (bus1.in_delay_slot)               m_epc = bus1.pc - 32'd4;
               else if (code == 5'd8 || code == 5'd9) m_epc = bus1.pc + 32'd4;
               else                                  m_epc = bus1.pc;
            end
         end
         m_hw = bus1.hw_int;
      end
      d2_k++;
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [4:0] a, input logic [31:0] d);
      bus1.we = 1'b1; bus1.waddr = a; bus1.wdata = d;
      cycle();
      bus1.we = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      bus1.we = 0; bus1.waddr = 0; bus1.wdata = 0; bus1.raddr = 5'd12; bus1.hw_int = 0;
      bus1.pc_valid = 1'b1; bus1.pc = 32'h40; bus1.in_delay_slot = 0; bus1.exc_req = 5'b00001;
      bus2.we = 0; bus2.waddr = 0; bus2.wdata = 0; bus2.raddr = 5'd9; bus2.hw_int = 0;
      bus2.pc_valid = 0; bus2.pc = 0; bus2.in_delay_slot = 0; bus2.exc_req = 0;
      repeat (2) @(posedge clk);
      #1;
      model_reset();
      #1;
      chk("rst_rdata", bus1.rdata, 32'd0);
      chk("rst_flush", {31'd0, bus1.exc_flush}, 32'd0);
      cycle();
      rst = 1'b0; bus1.pc_valid = 1'b0; bus1.exc_req = 0;
      #1;
      chk("reset_status", bus1.rdata, RESET_STATUS);
      bus1.raddr = 5'd15;
      #1;
      chk("prid", bus1.rdata, PRID);
      bus1.raddr = 5'd13;

      // timer: Compare=5, Count=0 -> fires five edges later, sticky, cleared by Compare write
      wr(5'd11, 32'd5);
      wr(5'd9, 32'd0);
      repeat (4) cycle();
      chk("timer_before", {31'd0, bus1.timer_int}, 32'd0);
      cycle();
      chk("timer_fire", {31'd0, bus1.timer_int}, 32'd1);
      chk("timer_ip7", {31'd0, bus1.cause[15]}, 32'd1);
      repeat (2) cycle();
      chk("timer_sticky", {31'd0, bus1.timer_int}, 32'd1);
      wr(5'd11, 32'd0);
      chk("timer_clear", {31'd0, bus1.timer_int}, 32'd0);

      // hardware interrupt entry
      bus1.hw_int = 6'b000001;
      wr(5'd12, 32'h0000_0401);
      bus1.pc_valid = 1'b1; bus1.pc = 32'h100;
      #1;
      chk("int_flush", {31'd0, bus1.exc_flush}, 32'd1);
      chk("int_target", bus1.exc_target, 32'hBFC0_0380);
      cycle();
      chk("int_epc", bus1.epc, 32'h100);
      chk("int_code", {27'd0, bus1.cause[6:2]}, 32'd0);
      chk("int_exl", {31'd0, bus1.status[1]}, 32'd1);
      bus1.pc_valid = 1'b0; bus1.hw_int = 0;
      cycle();

      // eret back, delay-slot syscall, nested break keeps EPC/BD
      bus1.pc_valid = 1'b1; bus1.exc_req = 5'b10000;
      #1;
      chk("eret1_target", bus1.exc_target, 32'h100);
      cycle();
      bus1.exc_req = 5'b00001; bus1.pc = 32'h200; bus1.in_delay_slot = 1'b1;
      cycle();
      chk("sys_epc", bus1.epc, 32'h1FC);
      chk("sys_bd", {31'd0, bus1.cause[31]}, 32'd1);
      chk("sys_code", {27'd0, bus1.cause[6:2]}, 32'd8);
      bus1.exc_req = 5'b00010; bus1.pc = 32'h400; bus1.in_delay_slot = 1'b0;
      cycle();
      chk("nested_code", {27'd0, bus1.cause[6:2]}, 32'd9);
      chk("nested_epc", bus1.epc, 32'h1FC);
      chk("nested_bd", {31'd0, bus1.cause[31]}, 32'd1);
      bus1.exc_req = 5'b10000;
      #1;
      chk("eret2_target", bus1.exc_target, 32'h1FC);
      cycle();
      chk("eret2_exl", {31'd0, bus1.status[1]}, 32'd0);

      // priority: interrupt over overflow over syscall; then with IE=0
      bus1.pc_valid = 1'b0; bus1.exc_req = 0; bus1.hw_int = 6'b000001;
      cycle();
      bus1.pc_valid = 1'b1; bus1.exc_req = 5'b01001;
      cycle();
      chk("prio_int", {27'd0, bus1.cause[6:2]}, 32'd0);
      bus1.exc_req = 5'b10000;
      cycle();
      bus1.pc_valid = 1'b0; bus1.exc_req = 0;
      wr(5'd12, 32'h0000_0400);
      bus1.pc_valid = 1'b1; bus1.exc_req = 5'b01001;
      cycle();
      chk("prio_ov", {27'd0, bus1.cause[6:2]}, 32'd12);
      bus1.exc_req = 5'b10000;
      cycle();
      bus1.pc_valid = 1'b0; bus1.exc_req = 0; bus1.hw_int = 0;

      // Count wrap, and divide-by-two on the second instance
      bus1.raddr = 5'd9;
      bus2.we = 1'b1; bus2.waddr = 5'd9; bus2.wdata = 32'd100;
      wr(5'd9, 32'hFFFF_FFFF);
      bus2.we = 1'b0;
      d2_base = 32'd100; d2_k = 0; d2_on = 1'b1;
      chk("count_max", bus1.rdata, 32'hFFFF_FFFF);
      cycle();
      chk("count_wrap", bus1.rdata, 32'd0);
      repeat (5) cycle();
      d2_on = 1'b0;

      // EPC write collides with reserved-instruction entry
      bus1.pc_valid = 1'b1; bus1.exc_req = 5'b00100; bus1.pc = 32'h300;
      wr(5'd14, 32'h55);
      chk("collide_epc", bus1.epc, 32'h300);
      chk("collide_code", {27'd0, bus1.cause[6:2]}, 32'd10);
      bus1.exc_req = 5'b10000;
      cycle();
      bus1.pc_valid = 1'b0; bus1.exc_req = 0;

      // only IP[1:0] of Cause is writable
      wr(5'd13, 32'hFFFF_FFFF);
      chk("cause_sw_ip", {30'd0, bus1.cause[9:8]}, 32'd3);
      chk("cause_ro", bus1.cause & 32'h3FFF_0083, 32'd0);

      for (int n = 0; n < 600; n++) begin
         rst = ($urandom_range(0, 99) < 2);
         bus1.we = ($urandom_range(0, 3) == 0);
         case ($urandom_range(0, 6))
            0: bus1.waddr = 5'd9;
            1: bus1.waddr = 5'd11;
            2: bus1.waddr = 5'd12;
            3: bus1.waddr = 5'd13;
            4: bus1.waddr = 5'd14;
            5: bus1.waddr = 5'd15;
            default: bus1.waddr = 5'($urandom);
         endcase
         bus1.wdata = $urandom;
         if (bus1.waddr == 5'd11) bus1.wdata = m_count + 32'($urandom_range(1, 8));
         if (bus1.waddr == 5'd12) bus1.wdata = $urandom & 32'h1000_FF03;
         case ($urandom_range(0, 6))
            0: bus1.raddr = 5'd9;
            1: bus1.raddr = 5'd11;
            2: bus1.raddr = 5'd12;
            3: bus1.raddr = 5'd13;
            4: bus1.raddr = 5'd14;
            5: bus1.raddr = 5'd15;
            default: bus1.raddr = 5'($urandom);
         endcase
         if ($urandom_range(0, 7) == 0) bus1.hw_int = 6'($urandom);
         bus1.pc_valid = 1'($urandom);
         bus1.pc = $urandom & 32'hFFFF_FFFC;
         bus1.in_delay_slot = 1'($urandom);
         bus1.exc_req = ($urandom_range(0, 2) == 0) ? 5'($urandom) : 5'd0;
         cycle();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/cp0_ctrl.md
CP0_CTRL -- requirements
Module: cp0_ctrl

Interface
REQ-001 Parameter NUM_HW_INT, default 6, number of hardware interrupt lines (legal 1..6).
REQ-002 Parameter TIMER_IP, default 7, Cause.IP bit driven by the timer (legal 2..7).
REQ-003 Parameter COUNT_DIV, default 1, Count increments every COUNT_DIV cycles (legal 1 or 2).
REQ-004 Parameter RESET_STATUS, default 32'h1000_0000, Status value after reset.
REQ-005 Parameter EXC_VECTOR, default 32'hBFC0_0380, exception handler entry address.
REQ-006 Parameter PRID, default 32'h0001_0001, read-only PRId value.
REQ-007 clk  in  1  clock; all state updates on rising edge.
REQ-008 rst  in  1  reset, synchronous, active-high.
REQ-009 we  in  1  CP0 register write enable; waddr in 5, wdata in 32.
REQ-010 raddr  in  5  read address; rdata  out  32  combinational read data.
REQ-011 hw_int  in  NUM_HW_INT  level hardware interrupt requests.
REQ-012 pc_valid  in  1  instruction present at pc; pc in 32; in_delay_slot in 1.
REQ-013 exc_req  in  5  bit0 syscall, bit1 break, bit2 reserved-instr, bit3 overflow, bit4 eret.
REQ-014 exc_flush  out  1  combinational; exception/eret taken this cycle.
REQ-015 exc_target  out  32  redirect pc, valid when exc_flush=1.
REQ-016 int_pending  out 1; timer_int  out 1; status out 32; cause out 32; epc out 32.

Function
REQ-017 Addresses: 9 Count, 11 Compare, 12 Status, 13 Cause, 14 EPC, 15 PRId (read-only); others read 0, writes ignored.
REQ-018 Status fields: IM[15:8], EXL[1], IE[0]; all 32 bits writable.
REQ-019 Cause fields: BD[31], TI[30], IP[15:8], ExcCode[6:2]; only IP[1:0] software-writable; others 0.
REQ-020 IP[2+i] = hw_int[i] registered one cycle, i<NUM_HW_INT; unused IP bits 0; IP[TIMER_IP] additionally ORed with timer_int.
REQ-021 Count +1 every COUNT_DIV cycles (divider phase register for 2), wraps 32'hFFFF_FFFF -> 0; Count write wins over increment and resets divider phase.
REQ-022 timer_int (= Cause.TI) sets on the edge where Count==Compare and Compare!=0; sticky until a Compare write, which clears it even on a same-cycle match.
REQ-023 int_pending = IE & ~EXL & |(IP & IM).
REQ-024 Taken event only when pc_valid=1; priority interrupt > reserved-instr > overflow > syscall > break > eret; one event per cycle.
REQ-025 ExcCode: interrupt 0, syscall 8, break 9, reserved-instr 10, overflow 12.
REQ-026 Exception entry: EXL<=1, ExcCode set, BD<=in_delay_slot, exc_target=EXC_VECTOR.
REQ-027 EPC: pc-4 if in_delay_slot; else pc+4 for syscall/break, pc otherwise.
REQ-028 Entry with EXL already 1: ExcCode updated, EPC and BD unchanged.
REQ-029 eret: EXL<=0, exc_target=EPC, no other field changes.
REQ-030 Same-cycle write and taken event: event updates to EXL, ExcCode, BD, EPC win; other written bits apply.
REQ-031 rdata reflects state before the current edge (no write bypass); Cause read shows live IP.

Reset
REQ-032 On rst: Count=0, Compare=0, Status=RESET_STATUS, Cause=0, EPC=0, divider phase 0, sampled hw_int=0, timer_int=0.
REQ-033 During rst: rdata=0, exc_flush=0, int_pending=0; rst mid-operation discards any pending event.

Verification
REQ-034 Write Compare=5, Count=0, COUNT_DIV=1 -> timer_int=1 and Cause[15]=1 five cycles later; Compare write -> 0 next cycle.
REQ-035 Status=32'h0000_0401, hw_int[0]=1 with pc=32'h100 valid -> exc_flush, exc_target=32'hBFC0_0380, EPC=32'h100, ExcCode=0, EXL=1.
REQ-036 syscall at pc=32'h200, in_delay_slot=1 -> EPC=32'h1FC, BD=1, ExcCode=8; eret then -> exc_target=32'h1FC, EXL=0.
REQ-037 syscall|overflow|interrupt same cycle -> ExcCode=0; with IE=0 -> ExcCode=12.
REQ-038 Count=32'hFFFF_FFFF -> 0 next cycle; COUNT_DIV=2 -> Count steps every second cycle.
REQ-039 Write EPC=32'h55 same cycle as RI at pc=32'h300 -> EPC=32'h300.
